// File: rtl/sram_march_bist.sv
// March BIST sequencer driving the ext_sram request port: W0(P), R0(P)/W1(~P) per word, R1(~P).
// Optional first-failure log enabled by defining SRAM_BIST_ERRLOG_EN.
module sram_march_bist #(
   parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
   parameter int unsigned WORDS     = 256,
   parameter int unsigned STRIDE    = 4,
   parameter logic [31:0] PATTERN   = 32'hAAAA_AAAA
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        start_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        pass_o,
   output logic [15:0] err_count_o,
   output logic        valid_o,
   output logic        rw_o,
   output logic [31:0] addri_o,
   output logic [31:0] dtw_o,
   input  logic        ready_i,
   input  logic [31:0] dtr_i,
   output logic [31:0] fail_addr_o,
   output logic [31:0] fail_exp_o,
   output logic [31:0] fail_act_o
);

   typedef enum logic [2:0] {StIdle, StW0, StR0, StW1, StR1, StFin} state_e;

   localparam logic [15:0] LastIdx = 16'(WORDS - 1);
   localparam logic [31:0] StrideW = 32'(STRIDE);
   localparam logic [31:0] PatInv  = ~PATTERN;

   state_e      state_q, state_d;
   logic        valid_q, valid_d;
   logic        rw_q, rw_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] dtw_q, dtw_d;
   logic [15:0] idx_q, idx_d;
   logic [15:0] err_q, err_d;

   logic        xfer;
   logic        last;
   logic        is_read;
   logic        mismatch;
   logic        accept;
   logic [31:0] exp_data;

   assign xfer     = valid_q & ready_i;
   assign last     = (idx_q == LastIdx);
   assign is_read  = (state_q == StR0) || (state_q == StR1);
   assign exp_data = (state_q == StR1) ? PatInv : PATTERN;
   assign mismatch = xfer & is_read & (dtr_i != exp_data);
   assign accept   = (state_q == StIdle) & start_i;

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      rw_d    = rw_q;
      busy_d  = busy_q;
      done_d  = done_q;
      addr_d  = addr_q;
      dtw_d   = dtw_q;
      idx_d   = idx_q;
      err_d   = err_q;

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = StW0;
               valid_d = 1'b1;
               rw_d    = 1'b1;
               addr_d  = ADDR_BASE;
               dtw_d   = PATTERN;
               idx_d   = 16'd0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               err_d   = 16'd0;
            end
         end
         // In active states valid re-asserts after the one-cycle gap that follows each ready.
         StW0: begin
            valid_d = 1'b1;
            if (xfer) begin
               valid_d = 1'b0;
               if (last) begin
                  state_d = StR0;
                  idx_d   = 16'd0;
                  addr_d  = ADDR_BASE;
                  rw_d    = 1'b0;
                  dtw_d   = 32'd0;
               end else begin
                  idx_d  = idx_q + 16'd1;
                  addr_d = addr_q + StrideW;
               end
            end
         end
         StR0: begin
            valid_d = 1'b1;
            if (xfer) begin
               valid_d = 1'b0;
               state_d = StW1;
               rw_d    = 1'b1;
               dtw_d   = PatInv;
            end
         end
         StW1: begin
            valid_d = 1'b1;
            if (xfer) begin
               valid_d = 1'b0;
               rw_d    = 1'b0;
               dtw_d   = 32'd0;
               if (last) begin
                  state_d = StR1;
                  idx_d   = 16'd0;
                  addr_d  = ADDR_BASE;
               end else begin
                  state_d = StR0;
                  idx_d   = idx_q + 16'd1;
                  addr_d  = addr_q + StrideW;
               end
            end
         end
         StR1: begin
            valid_d = 1'b1;
            if (xfer) begin
               valid_d = 1'b0;
               if (last) begin
                  state_d = StFin;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  idx_d  = idx_q + 16'd1;
                  addr_d = addr_q + StrideW;
               end
            end
         end
         StFin: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase

      if (mismatch && (err_q != 16'hFFFF)) begin
         err_d = err_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= StIdle;
         valid_q <= 1'b0;
         rw_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         addr_q  <= 32'd0;
         dtw_q   <= 32'd0;
         idx_q   <= 16'd0;
         err_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         rw_q    <= rw_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         addr_q  <= addr_d;
         dtw_q   <= dtw_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
      end
   end

`ifdef SRAM_BIST_ERRLOG_EN
   logic [31:0] fail_addr_q, fail_exp_q, fail_act_q;

   // Only the first mismatch of a run is logged; err_q==0 marks it.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         fail_addr_q <= 32'd0;
         fail_exp_q  <= 32'd0;
         fail_act_q  <= 32'd0;
      end else if (accept) begin
         fail_addr_q <= 32'd0;
         fail_exp_q  <= 32'd0;
         fail_act_q  <= 32'd0;
      end else if (mismatch && (err_q == 16'd0)) begin
         fail_addr_q <= addr_q;
         fail_exp_q  <= exp_data;
         fail_act_q  <= dtr_i;
      end
   end

   assign fail_addr_o = fail_addr_q;
   assign fail_exp_o  = fail_exp_q;
   assign fail_act_o  = fail_act_q;
`else
   assign fail_addr_o = 32'd0;
   assign fail_exp_o  = 32'd0;
   assign fail_act_o  = 32'd0;
`endif

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign pass_o      = done_q && (err_q == 16'd0);
   assign err_count_o = err_q;
   assign valid_o     = valid_q;
   assign rw_o        = rw_q;
   assign addri_o     = addr_q;
   assign dtw_o       = dtw_q;

endmodule

// File: tb/tb_sram_march_bist.sv
// Randomized scoreboard bench for sram_march_bist with a faultable SRAM responder.
module tb_sram_march_bist;

   localparam logic [31:0] Base   = 32'h0000_0010;
   localparam int unsigned Words  = 4;
   localparam int unsigned Stride = 4;
   localparam logic [31:0] Pat    = 32'hAAAA_AAAA;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        start_i;
   logic        busy_o, done_o, pass_o;
   logic [15:0] err_count_o;
   logic        valid_o, rw_o;
   logic [31:0] addri_o, dtw_o;
   logic        ready_i;
   logic [31:0] dtr_i;
   logic [31:0] fail_addr_o, fail_exp_o, fail_act_o;

   sram_march_bist #(
      .ADDR_BASE(Base),
      .WORDS    (Words),
      .STRIDE   (Stride),
      .PATTERN  (Pat)
   ) dut (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .start_i    (start_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .pass_o     (pass_o),
      .err_count_o(err_count_o),
      .valid_o    (valid_o),
      .rw_o       (rw_o),
      .addri_o    (addri_o),
      .dtw_o      (dtw_o),
      .ready_i    (ready_i),
      .dtr_i      (dtr_i),
      .fail_addr_o(fail_addr_o),
      .fail_exp_o (fail_exp_o),
      .fail_act_o (fail_act_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic        rw;
      logic [31:0] addr;
      logic [31:0] data;
   } txn_t;

   txn_t        exp_q[$];
   logic [31:0] mem[logic [31:0]];
   int          total = 0;
   int          bad = 0;
   int          hs_count = 0;
   int          fault_mode = 0;   // 0 clean, 1 bit0 stuck-at-0 at 0x18, 2 reads return 0
   int          lat_mode = 0;     // <0 random 0..4, else fixed latency
   int          wait_cnt = 0;
   int          cur_lat = 0;
   logic        prev_hs = 1'b0;
   logic        prev_valid = 1'b0;
   logic [31:0] prev_addr = 32'd0;
   logic [31:0] prev_dtw = 32'd0;
   logic        prev_rw = 1'b0;
   txn_t        mon_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   function automatic logic [31:0] faulty(input logic [31:0] a, input logic [31:0] v);
      case (fault_mode)
         1:       return (a == 32'h18) ? (v & 32'hFFFF_FFFE) : v;
         2:       return 32'd0;
         default: return v;
      endcase
   endfunction

   function automatic logic [31:0] word_addr(input int i);
      return Base + 32'(i) * 32'(Stride);
   endfunction

   function automatic int next_lat();
      return (lat_mode < 0) ? int'($urandom_range(0, 4)) : lat_mode;
   endfunction

   // SRAM responder: ready after cur_lat cycles of valid; dtr is junk outside ready.
   initial begin
      ready_i = 1'b0;
      dtr_i   = 32'd0;
      forever begin
         @(negedge clk_i);
         ready_i = 1'b0;
         dtr_i   = $urandom;
         if (reset_i) begin
            wait_cnt = 0;
         end else if (valid_o) begin
            if (wait_cnt >= cur_lat) begin
               ready_i = 1'b1;
               if (rw_o) mem[addri_o] = dtw_o;
               else dtr_i = faulty(addri_o, mem.exists(addri_o) ? mem[addri_o] : 32'd0);
               wait_cnt = 0;
               cur_lat  = next_lat();
            end else begin
               wait_cnt++;
            end
         end
      end
   end

   // Monitor: pops the expected transaction at each handshake and checks protocol.
   initial begin
      forever begin
         @(negedge clk_i);
         #2;
         if (reset_i) begin
            prev_hs    = 1'b0;
            prev_valid = 1'b0;
         end else begin
            if (prev_hs) check("gap after ready", 32'(valid_o), 32'd0);
            if (prev_valid && !prev_hs && valid_o) begin
               check("addr stable", addri_o, prev_addr);
               check("dtw stable", dtw_o, prev_dtw);
               check("rw stable", 32'(rw_o), 32'(prev_rw));
            end
            prev_hs    = valid_o && ready_i;
            prev_valid = valid_o;
            prev_addr  = addri_o;
            prev_dtw   = dtw_o;
            prev_rw    = rw_o;
            if (prev_hs) begin
               hs_count++;
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected txn: got addr %h rw %0d want none", addri_o, rw_o);
               end else begin
                  mon_e = exp_q.pop_front();
                  check("txn rw", 32'(rw_o), 32'(mon_e.rw));
                  check("txn addr", addri_o, mon_e.addr);
                  if (mon_e.rw) check("txn wdata", dtw_o, mon_e.data);
               end
            end
         end
      end
   end

   // Reference march: expected transactions plus error count and first-failure record.
   task automatic build_expect(output int exp_err, output logic [31:0] fa, output logic [31:0] fe,
                               output logic [31:0] fac);
      logic [31:0] a, rd;
      exp_q.delete();
      exp_err = 0;
      fa = 32'd0;
      fe = 32'd0;
      fac = 32'd0;
      for (int i = 0; i < int'(Words); i++) exp_q.push_back({1'b1, word_addr(i), Pat});
      for (int i = 0; i < int'(Words); i++) begin
         a = word_addr(i);
         exp_q.push_back({1'b0, a, 32'd0});
         rd = faulty(a, Pat);
         if (rd != Pat) begin
            if (exp_err == 0) begin fa = a; fe = Pat; fac = rd; end
            exp_err++;
         end
         exp_q.push_back({1'b1, a, ~Pat});
      end
      for (int i = 0; i < int'(Words); i++) begin
         a = word_addr(i);
         exp_q.push_back({1'b0, a, 32'd0});
         rd = faulty(a, ~Pat);
         if (rd != ~Pat) begin
            if (exp_err == 0) begin fa = a; fe = ~Pat; fac = rd; end
            exp_err++;
         end
      end
   endtask

   task automatic pulse_start();
      @(negedge clk_i);
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
   endtask

   task automatic run(input string tag, input int fmode, input int lmode, input bit pulse5);
      int exp_err, n;
      logic [31:0] fa, fe, fac;
      fault_mode = fmode;
      lat_mode   = lmode;
      cur_lat    = next_lat();
      wait_cnt   = 0;
      build_expect(exp_err, fa, fe, fac);
      hs_count = 0;
      pulse_start();
      check({tag, " busy after start"}, 32'(busy_o), 32'd1);
      check({tag, " done cleared"}, 32'(done_o), 32'd0);
      if (pulse5) begin
         n = 0;
         while (hs_count < 5 && n < 2000) begin @(negedge clk_i); n++; end
         pulse_start();
         check({tag, " busy through restart"}, 32'(busy_o), 32'd1);
         check({tag, " err kept mid-run"}, 32'(err_count_o != 16'd0), 32'(exp_err != 0));
      end
      n = 0;
      while (!done_o && n < 4000) begin @(negedge clk_i); n++; end
      if (!done_o) begin
         total++;
         bad++;
         $display("FAIL %s timeout: done=%0d want 1", tag, done_o);
      end
      @(negedge clk_i);
      check({tag, " done"}, 32'(done_o), 32'd1);
      check({tag, " busy idle"}, 32'(busy_o), 32'd0);
      check({tag, " err_count"}, 32'(err_count_o), 32'(exp_err));
      check({tag, " pass"}, 32'(pass_o), 32'(exp_err == 0));
      check({tag, " txn count"}, 32'(hs_count), 32'(4 * Words));
      check({tag, " queue empty"}, 32'(exp_q.size()), 32'd0);
`ifdef SRAM_BIST_ERRLOG_EN
      check({tag, " fail_addr"}, fail_addr_o, fa);
      check({tag, " fail_exp"}, fail_exp_o, fe);
      check({tag, " fail_act"}, fail_act_o, fac);
`else
      check({tag, " fail_addr"}, fail_addr_o, 32'd0);
      check({tag, " fail_exp"}, fail_exp_o, 32'd0);
      check({tag, " fail_act"}, fail_act_o, 32'd0);
`endif
      repeat (2) @(negedge clk_i);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: sim time exceeded, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int n, exp_err;
      logic [31:0] fa, fe, fac;
      reset_i = 1'b1;
      start_i = 1'b0;
      repeat (3) @(negedge clk_i);
      check("rst valid", 32'(valid_o), 32'd0);
      check("rst rw", 32'(rw_o), 32'd0);
      check("rst addri", addri_o, 32'd0);
      check("rst dtw", dtw_o, 32'd0);
      check("rst busy", 32'(busy_o), 32'd0);
      check("rst done", 32'(done_o), 32'd0);
      check("rst pass", 32'(pass_o), 32'd0);
      check("rst err", 32'(err_count_o), 32'd0);
      check("rst fail_addr", fail_addr_o, 32'd0);
      reset_i = 1'b0;
      repeat (2) @(negedge clk_i);

      run("clean", 0, 3, 1'b0);
      run("stuck0", 1, -1, 1'b0);
      run("zerolat", 0, 0, 1'b0);
      run("restart", 2, 2, 1'b1);

      // Abort in R0 with a request outstanding.
      fault_mode = 0;
      lat_mode   = 3;
      cur_lat    = 3;
      wait_cnt   = 0;
      build_expect(exp_err, fa, fe, fac);
      hs_count = 0;
      pulse_start();
      n = 0;
      while (!(hs_count >= 4 && valid_o && !rw_o) && n < 2000) begin @(negedge clk_i); n++; end
      check("abort reached R0", 32'(valid_o && !rw_o), 32'd1);
      #2 reset_i = 1'b1;
      #1;
      check("abort valid", 32'(valid_o), 32'd0);
      check("abort busy", 32'(busy_o), 32'd0);
      check("abort done", 32'(done_o), 32'd0);
      exp_q.delete();
      repeat (2) @(negedge clk_i);
      reset_i = 1'b0;
      repeat (2) @(negedge clk_i);
      run("postrst", 0, 3, 1'b0);

      run("allfail", 2, -1, 1'b0);
      for (int k = 0; k < 4; k++) run("random", int'($urandom_range(0, 2)), -1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sram_march_bist.md
Name: sram_march_bist

Overview:
- Built-in self-test sequencer sitting directly upstream of the external SRAM controller (ext_sram) on its request port.
- On `start`, runs a 3-phase march test over a word range:
  - write P to every word;
  - read-expect P, then write ~P, per word;
  - read-expect ~P.
- Counts read mismatches and reports pass/fail.
- Replaces hand-coded single-word probe FSMs at board top level.

Parameters:
- ADDR_BASE, 32'h0000_0000, byte address of first tested word.
- WORDS, 256, number of 32-bit words tested; legal range 1..65535.
- STRIDE, 4, byte increment between consecutive words.
- PATTERN, 32'hAAAA_AAAA, background pattern P; inverse pattern is ~P.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level-sampled; a high sample in IDLE launches a run.
- busy  out  1  high from the cycle after start is accepted until FIN.
- done  out  1  set in FIN, held until next accepted start or reset.
- pass  out  1  done && err_count==0; 0 whenever done=0.
- err_count  out  16  mismatch count; saturates at 16'hFFFF.
- valid  out  1  request valid to ext_sram.
- rw  out  1  1=write, 0=read.
- addri  out  32  request byte address.
- dtw  out  32  write data.
- ready  in  1  one-cycle completion pulse from ext_sram.
- dtr  in  32  read data; valid in the cycle ready=1 for reads.
- fail_addr  out  32  first failing address (SRAM_BIST_ERRLOG_EN only, else 0).
- fail_exp  out  32  expected data at first failure (SRAM_BIST_ERRLOG_EN only, else 0).
- fail_act  out  32  actual data at first failure (SRAM_BIST_ERRLOG_EN only, else 0).

Behaviour:
- Reset values: all outputs 0, including valid, rw, addri, dtw, busy, done, pass, err_count, and the fail_* registers. State=IDLE. Reset is asynchronous, so valid drops immediately even mid-transaction.
- States and transitions:
  - IDLE -> W0 when start=1.
  - W0 -> R0 after the last word.
  - R0 -> W1 after each R0 completion (same address).
  - W1 -> R0 at the next address, or -> R1 when the last word is done.
  - R1 -> FIN after the last word.
  - FIN -> IDLE after one cycle; done stays held.
- Accepting start: clears done, err_count and fail_*; loads addri=ADDR_BASE.
- Request rules:
  - addri, rw and dtw are stable while valid=1.
  - valid stays high until ready is sampled high.
  - In the cycle after ready, valid=0 and addri/rw/dtw update.
  - valid re-asserts the following cycle.
  - Minimum 1-cycle gap between requests. Transactions never overlap.
- Ready timing: a ready arriving with valid=0 is ignored. Ready in the same cycle valid rises completes that transaction.
- Data per state: W0 writes P; W1 writes ~P; R0 compares dtr to P; R1 compares dtr to ~P. The compare happens in the ready cycle.
- Addressing: address = ADDR_BASE + i*STRIDE, 32-bit modulo arithmetic (wrap past 32'hFFFF_FFFF allowed). Word index i is a 16-bit counter, 0..WORDS-1.
- Run length: exactly 4*WORDS transactions in total.
- Mismatch: err_count increments by 1, saturating at 16'hFFFF.
- start handling: ignored while busy=1. A start held high through FIN re-launches from IDLE.
- Reset during a run: aborts immediately; no partial-result reporting.

Optional Feature:
- SRAM_BIST_ERRLOG_EN:
  - Defined: on the first mismatch of a run (err_count==0 at compare), capture fail_addr=addri, fail_exp=expected, fail_act=dtr. Later mismatches do not overwrite. Cleared on start accept.
  - Undefined: fail_* tied to 0 and no capture registers are built.

Test Plan:
- Clean run: model with ready 3 cycles after valid, WORDS=4, ADDR_BASE=0x10.
  -> 16 transactions with addresses 0x10,0x14,0x18,0x1C.
  -> Order: W0×4, then (R0,W1)×4, then R1×4.
  -> done=1, pass=1, err_count=0.
- Stuck-at-0 bit0 at 0x18, WORDS=4.
  -> R0 passes (P bit0=0); R1 fails.
  -> err_count=1, pass=0.
  -> With SRAM_BIST_ERRLOG_EN: fail_addr=0x18, fail_exp=0x5555_5555, fail_act=0x5555_5554.
- Zero-latency model (ready in the valid-rise cycle), WORDS=2.
  -> 8 transactions, each valid pulse 1 cycle wide with 1-cycle gaps.
  -> pass=1.
- start pulsed again at transaction 5 of a WORDS=4 run.
  -> Ignored; run still completes 16 transactions.
  -> err_count is not cleared mid-run.
- reset asserted mid-R0 with valid=1.
  -> valid, busy, done=0 asynchronously.
  -> After release, start runs a full clean pass from ADDR_BASE.
- All-fail model (returns 0 on every read), WORDS=4, PATTERN=0xFFFF_FFFF.
  -> R0 reads fail 4 times; R1 expects 0 and passes.
  -> err_count=4.
  -> With the macro: fail_addr=ADDR_BASE, fail_act=0.
